// File: rtl/timer_ctrl_pkg.sv
// Shared types and encodings for the interval-timer controller and its prescaler.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } timer_state_e;

  localparam logic CNT_COUNT = 1'b0;
  localparam logic CNT_LOAD  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Clock-cycle prescaler: counts 0..limit_i while enabled and emits one tick per wrap.
module timer_prescaler #(
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      clear_i,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] limit_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] count_q, count_d;

  assign tick_o = en_i && (count_q == limit_i);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tick_o ? '0 : count_q + PRESCALE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_controller.sv
// Interval timer sequencer driving an external up-counter (count/load, no enable).
// Define TIMER_CTRL_OVERRUN_EN to build the sticky overrun flag; otherwise overrun_o is 0.
module timer_controller
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      periodic_i,
  input  logic [WORD_WIDTH-1:0]     period_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      cnt_action_o,
  output logic [WORD_WIDTH-1:0]     cnt_d_o,
  input  logic [WORD_WIDTH-1:0]     cnt_q_i,
  input  logic                      cnt_will_overflow_i,
  output logic                      irq_o,
  input  logic                      irq_ack_i,
  output logic                      busy_o,
  output logic                      overrun_o
);

  timer_state_e              state_q, state_d;
  logic [WORD_WIDTH-1:0]     period_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      periodic_q;
  logic                      irq_q;
  logic                      tick;
  logic                      expiry;
  logic                      restart;
  logic [WORD_WIDTH-1:0]     reload;

  // Two's-complement negate gives 2^W - period, and 0 for period 0 (full 2^W ticks).
  assign reload  = '0 - period_q;
  assign restart = start_i && !stop_i;
  assign expiry  = (state_q == RUN) && tick && cnt_will_overflow_i;

  timer_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clear_i  (state_q != RUN),
    .en_i     (state_q == RUN),
    .limit_i  (prescale_q),
    .tick_o   (tick)
  );

  // Default is hold: reload the counter with its own value.
  always_comb begin
    cnt_action_o = CNT_LOAD;
    cnt_d_o      = cnt_q_i;
    unique case (state_q)
      LOAD: cnt_d_o = reload;
      RUN: begin
        if (tick) begin
          if (cnt_will_overflow_i) begin
            if (periodic_q) cnt_d_o = reload;
          end else begin
            cnt_action_o = CNT_COUNT;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = LOAD;
    end else begin
      unique case (state_q)
        LOAD:    state_d = RUN;
        RUN:     if (expiry && !periodic_q) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      period_q   <= '0;
      prescale_q <= '0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= expiry || (irq_q && !irq_ack_i);
      if (restart) begin
        period_q   <= period_i;
        prescale_q <= prescale_i;
        periodic_q <= periodic_i;
      end
    end
  end

  assign irq_o  = irq_q;
  assign busy_o = (state_q == LOAD) || (state_q == RUN);

`ifdef TIMER_CTRL_OVERRUN_EN
  logic overrun_q;

  // An accepted start clears the flag even if an expiry lands in the same cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      overrun_q <= 1'b0;
    end else if (restart) begin
      overrun_q <= 1'b0;
    end else if (expiry && irq_q && !irq_ack_i) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

endmodule
